// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the writeback/commit stage: FSM states, load op codes,
// exception source bit positions and the architectural exception codes.
package wb_commit_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_LD = 2'd2
    } wb_state_e;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_BU   = 3'd2;
    localparam logic [2:0] LD_H    = 3'd3;
    localparam logic [2:0] LD_HU   = 3'd4;
    localparam logic [2:0] LD_W    = 3'd5;

    localparam int EXC_INT     = 0;
    localparam int EXC_ADEF    = 1;
    localparam int EXC_SYSCALL = 2;
    localparam int EXC_BRK     = 3;
    localparam int EXC_INE     = 4;
    localparam int EXC_ALE     = 5;

    localparam logic [5:0] ECODE_INT     = 6'h00;
    localparam logic [5:0] ECODE_ADEF    = 6'h08;
    localparam logic [5:0] ECODE_ALE     = 6'h09;
    localparam logic [5:0] ECODE_SYSCALL = 6'h0B;
    localparam logic [5:0] ECODE_BRK     = 6'h0C;
    localparam logic [5:0] ECODE_INE     = 6'h0D;

    // Op codes 6 and 7 are reserved and behave as "no load".
    function automatic logic is_load(input logic [2:0] op);
        return (op >= LD_B) && (op <= LD_W);
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data alignment: selects the addressed byte/half lane of the
// returned word and sign- or zero-extends it according to the load op.
module wb_load_align
    import wb_commit_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [2:0]        i_ld_op,
    input  logic [1:0]        i_off,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection then extension; lanes assume a 4-byte word.
    always_comb begin
        w_byte = 8'd0;
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data = i_rdata;
        case (i_ld_op)
            LD_B:    o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_BU:   o_data = {{(DATA_W-8){1'b0}}, w_byte};
            LD_H:    o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_HU:   o_data = {{(DATA_W-16){1'b0}}, w_half};
            LD_W:    o_data = i_rdata;
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: holds one instruction from MEM, waits for load data when
// needed, and commits its GPR write, CSR write, exception or ertn exactly once.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int CSR_AW = 14,
    parameter int ESUB_W = 9,
    parameter int EXC_N  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              wb_allowin,
    input  logic              mem_to_wb_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_rf_we,
    input  logic [RF_AW-1:0]  in_rf_waddr,
    input  logic [DATA_W-1:0] in_rf_wdata,
    input  logic [2:0]        in_ld_op,
    input  logic [1:0]        in_ld_off,
    input  logic              in_csr_re,
    input  logic              in_csr_we,
    input  logic [CSR_AW-1:0] in_csr_num,
    input  logic [DATA_W-1:0] in_csr_wmask,
    input  logic [DATA_W-1:0] in_csr_wval,
    input  logic              in_ertn,
    input  logic [EXC_N-1:0]  in_exc,
    input  logic [ESUB_W-1:0] in_esubcode,
    input  logic              rdata_valid,
    input  logic [DATA_W-1:0] rdata,
    output logic              csr_re,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_num,
    output logic [DATA_W-1:0] csr_wmask,
    output logic [DATA_W-1:0] csr_wvalue,
    input  logic [DATA_W-1:0] csr_rvalue,
    output logic              wb_ex,
    output logic [5:0]        wb_ecode,
    output logic [ESUB_W-1:0] wb_esub,
    output logic [DATA_W-1:0] wb_ex_pc,
    output logic              ertn_flush,
    output logic              fwd_we,
    output logic              fwd_busy,
    output logic [RF_AW-1:0]  fwd_waddr,
    output logic [DATA_W-1:0] fwd_wdata,
    output logic [DATA_W-1:0] debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [RF_AW-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;
    logic [DATA_W-1:0] r_pc;
    logic              r_rf_we;
    logic [RF_AW-1:0]  r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [2:0]        r_ld_op;
    logic [1:0]        r_ld_off;
    logic              r_csr_re;
    logic              r_csr_we;
    logic [CSR_AW-1:0] r_csr_num;
    logic [DATA_W-1:0] r_csr_wmask;
    logic [DATA_W-1:0] r_csr_wval;
    logic              r_ertn;
    logic [EXC_N-1:0]  r_exc;
    logic [ESUB_W-1:0] r_esubcode;

    logic              w_resident;
    logic              w_retire;
    logic              w_exc;
    logic              w_flush;
    logic              w_accept;
    logic              w_rf_commit;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_final_data;
    logic [5:0]        w_ecode;

    assign w_resident  = (r_state != ST_EMPTY);
    assign w_retire    = (r_state == ST_HOLD) | ((r_state == ST_WAIT_LD) & rdata_valid);
    assign w_exc       = |r_exc;
    assign w_flush     = w_retire & (w_exc | r_ertn);
    assign wb_allowin  = resetn & ((r_state == ST_EMPTY) | w_retire) & ~w_flush;
    assign w_accept    = mem_to_wb_valid & wb_allowin;
    assign w_rf_commit = w_retire & r_rf_we & ~w_exc;

    wb_load_align #(.DATA_W(DATA_W)) u_load_align (
        .i_rdata (rdata),
        .i_ld_op (r_ld_op),
        .i_off   (r_ld_off),
        .o_data  (w_ld_data)
    );

    // Next-state logic; a flush always coincides with retire so it lands in EMPTY.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (is_load(in_ld_op) && ~|in_exc) begin
                w_state_nxt = ST_WAIT_LD;
            end else begin
                w_state_nxt = ST_HOLD;
            end
        end else if (w_retire) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State register and instruction latch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_EMPTY;
            r_pc        <= {DATA_W{1'b0}};
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= {RF_AW{1'b0}};
            r_rf_wdata  <= {DATA_W{1'b0}};
            r_ld_op     <= 3'd0;
            r_ld_off    <= 2'd0;
            r_csr_re    <= 1'b0;
            r_csr_we    <= 1'b0;
            r_csr_num   <= {CSR_AW{1'b0}};
            r_csr_wmask <= {DATA_W{1'b0}};
            r_csr_wval  <= {DATA_W{1'b0}};
            r_ertn      <= 1'b0;
            r_exc       <= {EXC_N{1'b0}};
            r_esubcode  <= {ESUB_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pc        <= in_pc;
                r_rf_we     <= in_rf_we;
                r_rf_waddr  <= in_rf_waddr;
                r_rf_wdata  <= in_rf_wdata;
                r_ld_op     <= in_ld_op;
                r_ld_off    <= in_ld_off;
                r_csr_re    <= in_csr_re;
                r_csr_we    <= in_csr_we;
                r_csr_num   <= in_csr_num;
                r_csr_wmask <= in_csr_wmask;
                r_csr_wval  <= in_csr_wval;
                r_ertn      <= in_ertn;
                r_exc       <= in_exc;
                r_esubcode  <= in_esubcode;
            end
        end
    end

    // Exception code priority: INT > ADEF > SYSCALL > BRK > INE > ALE.
    always_comb begin
        w_ecode = ECODE_INT;
        if (r_exc[EXC_INT]) begin
            w_ecode = ECODE_INT;
        end else if (r_exc[EXC_ADEF]) begin
            w_ecode = ECODE_ADEF;
        end else if (r_exc[EXC_SYSCALL]) begin
            w_ecode = ECODE_SYSCALL;
        end else if (r_exc[EXC_BRK]) begin
            w_ecode = ECODE_BRK;
        end else if (r_exc[EXC_INE]) begin
            w_ecode = ECODE_INE;
        end else if (r_exc[EXC_ALE]) begin
            w_ecode = ECODE_ALE;
        end else begin
            w_ecode = 6'd0;
        end
    end

    // Result select: CSR read value wins over load data, which wins over the ALU result.
    always_comb begin
        w_final_data = r_rf_wdata;
        if (r_csr_re) begin
            w_final_data = csr_rvalue;
        end else if (is_load(r_ld_op)) begin
            w_final_data = w_ld_data;
        end else begin
            w_final_data = r_rf_wdata;
        end
    end

    assign csr_re     = w_resident & r_csr_re;
    assign csr_num    = w_resident ? r_csr_num : {CSR_AW{1'b0}};
    assign csr_we     = w_retire & r_csr_we & ~w_exc;
    assign csr_wmask  = r_csr_wmask;
    assign csr_wvalue = r_csr_wval;

    assign wb_ex      = w_retire & w_exc;
    assign wb_ecode   = w_ecode;
    assign wb_esub    = r_esubcode;
    assign wb_ex_pc   = r_pc;
    assign ertn_flush = w_retire & r_ertn & ~w_exc;

    assign fwd_we    = w_resident & r_rf_we & ~w_exc;
    assign fwd_busy  = (r_state == ST_WAIT_LD) & ~rdata_valid & r_rf_we;
    assign fwd_waddr = r_rf_waddr;
    assign fwd_wdata = w_final_data;

    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_we    = {4{w_rf_commit}};
    assign debug_wb_rf_wnum  = r_rf_waddr;
    assign debug_wb_rf_wdata = w_final_data;

endmodule
